// File: rtl/sa_pkg.sv
// Shared types and geometry helpers for the multi-tile systolic array sequencer.
package sa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } sa_tile_state_e;

  // Skewed stream length: words read from the input port per tile.
  function automatic int calc_l(input int rows, input int cols);
    return cols + rows - 1;
  endfunction

  // Cycles from the first PRELOAD cycle of one tile to that of the next.
  function automatic int calc_t(input int rows, input int cols);
    return 2 * rows + 2 * cols + 1;
  endfunction

  function automatic int calc_stream_len(input int rows, input int cols);
    return 2 * cols + rows;
  endfunction

endpackage

// File: rtl/sa_tile_control_if.sv
// Command, SRAM-port and array-control bundle between the top-level and the tile sequencer.
interface sa_tile_control_if #(
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4,
  parameter int MAX_TILES     = 8,
  parameter int INPUT_HEIGHT  = MAX_TILES * 64,
  parameter int WEIGHT_HEIGHT = MAX_TILES * 64,
  parameter int OUTPUT_HEIGHT = MAX_TILES * 64,
  parameter int PSUM_HEIGHT   = MAX_TILES * 64
) ();
  import sa_pkg::*;

  localparam int NT_W = $clog2(MAX_TILES + 1);
  localparam int IA_W = $clog2(INPUT_HEIGHT);
  localparam int WA_W = $clog2(WEIGHT_HEIGHT);
  localparam int OA_W = $clog2(OUTPUT_HEIGHT);
  localparam int PA_W = $clog2(PSUM_HEIGHT);

  // Command side: i_start is a level sampled only while idle; i_abort is honoured
  // in any busy state. There is no ready: a start seen while busy is dropped.
  logic                i_start;
  logic [NT_W-1:0]     i_num_tiles;
  logic                i_accumulate;
  logic                i_abort;
  logic                o_busy;
  logic                o_done;

  logic                r_input_cenb;
  logic                r_input_wenb;
  logic [IA_W-1:0]     r_input_addr;
  logic                r_weight_cenb;
  logic                r_weight_wenb;
  logic [WA_W-1:0]     r_weight_addr;
  logic                w_output_cenb;
  logic                w_output_wenb;
  logic [OA_W-1:0]     w_output_addr;
  logic                r_psum_cenb;
  logic [PA_W-1:0]     r_psum_addr;

  logic                o_mode;
  logic                o_load_psum;
  logic                o_psum_zero;
  sa_tile_state_e      o_state;

  modport master (
    output i_start, i_num_tiles, i_accumulate, i_abort,
    input  o_busy, o_done,
    input  r_input_cenb, r_input_wenb, r_input_addr,
    input  r_weight_cenb, r_weight_wenb, r_weight_addr,
    input  w_output_cenb, w_output_wenb, w_output_addr,
    input  r_psum_cenb, r_psum_addr,
    input  o_mode, o_load_psum, o_psum_zero, o_state
  );

  modport slave (
    input  i_start, i_num_tiles, i_accumulate, i_abort,
    output o_busy, o_done,
    output r_input_cenb, r_input_wenb, r_input_addr,
    output r_weight_cenb, r_weight_wenb, r_weight_addr,
    output w_output_cenb, w_output_wenb, w_output_addr,
    output r_psum_cenb, r_psum_addr,
    output o_mode, o_load_psum, o_psum_zero, o_state
  );

endinterface

// File: rtl/sa_addr_gen.sv
// Base-plus-offset address counter: clear wins over load, load wins over increment.
module sa_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic          i_inc,
  input  logic [AW-1:0] i_base,
  output logic [AW-1:0] o_addr
);

  logic [AW-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_base;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/sa_tile_control.sv
// Multi-tile weight-stationary sequencer: runs N preload/stream tiles per start command.
module sa_tile_control
  import sa_pkg::*;
#(
  parameter int NUM_ROWS      = 4,
  parameter int NUM_COLS      = 4,
  parameter int MAX_TILES     = 8,
  parameter int INPUT_HEIGHT  = MAX_TILES * 64,
  parameter int WEIGHT_HEIGHT = MAX_TILES * 64,
  parameter int OUTPUT_HEIGHT = MAX_TILES * 64,
  parameter int PSUM_HEIGHT   = MAX_TILES * 64
) (
  input logic              clk,
  input logic              rst_n,
  sa_tile_control_if.slave bus
);

  localparam int L    = calc_l(NUM_ROWS, NUM_COLS);
  localparam int SLEN = calc_stream_len(NUM_ROWS, NUM_COLS);
  localparam int CW   = $clog2(SLEN + 1);
  localparam int NT_W = $clog2(MAX_TILES + 1);
  localparam int IA_W = $clog2(INPUT_HEIGHT);
  localparam int WA_W = $clog2(WEIGHT_HEIGHT);
  localparam int OA_W = $clog2(OUTPUT_HEIGHT);
  localparam int PA_W = $clog2(PSUM_HEIGHT);

  if (INPUT_HEIGHT < MAX_TILES * L) begin : g_bad_input_height
    $error("INPUT_HEIGHT too small for MAX_TILES tiles");
  end
  if (OUTPUT_HEIGHT < MAX_TILES * L) begin : g_bad_output_height
    $error("OUTPUT_HEIGHT too small for MAX_TILES tiles");
  end
  if (PSUM_HEIGHT < MAX_TILES * L) begin : g_bad_psum_height
    $error("PSUM_HEIGHT too small for MAX_TILES tiles");
  end
  if (WEIGHT_HEIGHT < MAX_TILES * NUM_ROWS) begin : g_bad_weight_height
    $error("WEIGHT_HEIGHT too small for MAX_TILES tiles");
  end

  sa_tile_state_e  r_state;
  logic [CW-1:0]   r_cnt;
  logic [NT_W-1:0] r_tile;
  logic [NT_W-1:0] r_num;
  logic            r_acc;

  logic            w_pre, w_str, w_first, w_abort;
  logic            w_wt_rd, w_in_rd, w_ps_rd, w_out_wr, w_out_first;
  logic [NT_W-1:0] w_num_clamp;
  logic [WA_W-1:0] w_wt_base, w_wt_addr;
  logic [IA_W-1:0] w_in_base, w_in_addr;
  logic [OA_W-1:0] w_out_base, w_out_addr;
  logic [PA_W-1:0] w_ps_addr;

  assign w_pre       = (r_state == PRELOAD);
  assign w_str       = (r_state == STREAM);
  assign w_first     = (r_cnt == '0);
  assign w_abort     = bus.i_abort && (r_state != IDLE);
  assign w_wt_rd     = w_pre && (r_cnt < CW'(NUM_ROWS));
  assign w_in_rd     = w_str && (r_cnt < CW'(L));
  assign w_ps_rd     = w_in_rd && r_acc && (r_tile != '0);
  // The array needs NUM_COLS+1 cycles of fill before the first result emerges.
  assign w_out_wr    = w_str && (r_cnt > CW'(NUM_COLS));
  assign w_out_first = w_str && (r_cnt == CW'(NUM_COLS + 1));
  assign w_num_clamp = (bus.i_num_tiles > NT_W'(MAX_TILES)) ? NT_W'(MAX_TILES) : bus.i_num_tiles;

  assign w_wt_base  = WA_W'(r_tile) * WA_W'(NUM_ROWS);
  assign w_in_base  = IA_W'(r_tile) * IA_W'(L);
  assign w_out_base = r_acc ? '0 : OA_W'(r_tile) * OA_W'(L);

  sa_addr_gen #(.AW(WA_W)) u_weight_addr (
    .clk(clk), .rst_n(rst_n), .i_clear(w_abort),
    .i_load(w_wt_rd && w_first), .i_inc(w_wt_rd), .i_base(w_wt_base), .o_addr(w_wt_addr)
  );

  sa_addr_gen #(.AW(IA_W)) u_input_addr (
    .clk(clk), .rst_n(rst_n), .i_clear(w_abort),
    .i_load(w_in_rd && w_first), .i_inc(w_in_rd), .i_base(w_in_base), .o_addr(w_in_addr)
  );

  sa_addr_gen #(.AW(OA_W)) u_output_addr (
    .clk(clk), .rst_n(rst_n), .i_clear(w_abort),
    .i_load(w_out_first), .i_inc(w_out_wr), .i_base(w_out_base), .o_addr(w_out_addr)
  );

  sa_addr_gen #(.AW(PA_W)) u_psum_addr (
    .clk(clk), .rst_n(rst_n), .i_clear(w_abort),
    .i_load(w_ps_rd && w_first), .i_inc(w_ps_rd), .i_base('0), .o_addr(w_ps_addr)
  );

  assign bus.r_weight_addr = w_wt_addr;
  assign bus.r_input_addr  = w_in_addr;
  assign bus.w_output_addr = w_out_addr;
  assign bus.r_psum_addr   = w_ps_addr;
  assign bus.o_state       = r_state;

  always_ff @(posedge clk) begin
    bus.r_input_wenb  <= 1'b1;
    bus.r_weight_wenb <= 1'b1;
    if (!rst_n) begin
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_tile            <= '0;
      r_num             <= '0;
      r_acc             <= 1'b0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_mode        <= 1'b0;
      bus.o_load_psum   <= 1'b0;
      bus.o_psum_zero   <= 1'b1;
      bus.r_weight_cenb <= 1'b1;
      bus.r_input_cenb  <= 1'b1;
      bus.r_psum_cenb   <= 1'b1;
      bus.w_output_cenb <= 1'b1;
      bus.w_output_wenb <= 1'b1;
    end else if (w_abort) begin
      // Abort bypasses the state decode so every port is quiet on the very next cycle.
      r_state           <= IDLE;
      r_cnt             <= '0;
      r_tile            <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_mode        <= 1'b0;
      bus.o_load_psum   <= 1'b0;
      bus.o_psum_zero   <= 1'b1;
      bus.r_weight_cenb <= 1'b1;
      bus.r_input_cenb  <= 1'b1;
      bus.r_psum_cenb   <= 1'b1;
      bus.w_output_cenb <= 1'b1;
      bus.w_output_wenb <= 1'b1;
    end else begin
      bus.o_busy        <= (r_state != IDLE);
      bus.o_done        <= (r_state == DONE);
      bus.o_mode        <= w_str;
      bus.o_load_psum   <= w_str;
      bus.o_psum_zero   <= !(w_str && r_acc && (r_tile != '0));
      bus.r_weight_cenb <= !w_wt_rd;
      bus.r_input_cenb  <= !w_in_rd;
      bus.r_psum_cenb   <= !w_ps_rd;
      bus.w_output_cenb <= !w_out_wr;
      bus.w_output_wenb <= !w_out_wr;

      case (r_state)
        IDLE: begin
          if (bus.i_start && !bus.i_abort) begin
            r_num   <= w_num_clamp;
            r_acc   <= bus.i_accumulate;
            r_tile  <= '0;
            r_cnt   <= '0;
            r_state <= (w_num_clamp == '0) ? DONE : PRELOAD;
          end
        end
        PRELOAD: begin
          if (r_cnt == CW'(NUM_ROWS)) begin
            r_cnt   <= '0;
            r_state <= STREAM;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STREAM: begin
          if (r_cnt == CW'(SLEN - 1)) begin
            r_cnt <= '0;
            if ((r_tile + 1'b1) < r_num) begin
              r_tile  <= r_tile + 1'b1;
              r_state <= PRELOAD;
            end else begin
              r_state <= DONE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
